viterbi_stream_decoder: RTL and testbench

- Parametrised successor to the team's fixed 5-symbol, K=3 hard-decision Viterbi decoder.
- Streams frames of FRAME_LEN rate-1/2 hard symbols in through a valid/ready handshake.
- For each frame it runs add-compare-select (ACS), then traceback, then presents the decoded bits, the re-encoded corrected codeword and the final path metric behind a valid/ready output handshake.
- It sits between the channel symbol slicer and the frame consumer.

---
 rtl/viterbi_stream_decoder.sv | 274 +++++++++++++++++++++++++++
 tb/tb_viterbi_stream_decoder.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_stream_decoder.sv
// ---------------------------------------------------------------------------
// viterbi_stream_decoder
//
// Frame-based hard-decision Viterbi decoder for a rate-1/2, K=3 convolutional
// code. A frame of FRAME_LEN received symbols is collected through a
// valid/ready input handshake. The decoder then runs one add-compare-select
// step per cycle over the whole frame, traces back through the survivor
// memory one step per cycle, and finally presents the decoded bits, the
// re-encoded (corrected) codeword and the final path metric behind a
// valid/ready output handshake.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous, active-low reset
//   in_sym[1:0]         received hard symbol {c1,c0}
//   in_valid            in_sym is valid
//   in_ready            decoder accepts a symbol this cycle
//   out_valid           frame results valid, held until accepted
//   out_ready           consumer accepts results
//   decoded_bits        bit t = decoded input of trellis step t
//   corrected_codeword  bits [2t+1:2t] = re-encoded symbol of step t
//   path_metric_out     metric of the traceback start state
//   err_total[15:0]     only with VITERBI_ERR_CNT_EN: running, saturating
//                       sum of path_metric_out over accepted frames
//
// Optional feature macro: VITERBI_ERR_CNT_EN
//
// Trellis state is {s1,s0} with s1 the most recent input bit. Input u moves
// state {a,b} to {u,a}; the branch output is computed from the register
// {u,a,b} masked by the generator polynomials G1 (c1) and G2 (c0).
// ---------------------------------------------------------------------------
module viterbi_stream_decoder #(
  parameter int         FRAME_LEN  = 8,
  parameter logic [2:0] G1         = 3'b111,
  parameter logic [2:0] G2         = 3'b101,
  parameter int         PM_W       = 8,
  parameter int         TERMINATED = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             in_sym,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FRAME_LEN-1:0]   decoded_bits,
  output logic [2*FRAME_LEN-1:0] corrected_codeword,
  output logic [PM_W-1:0]        path_metric_out
`ifdef VITERBI_ERR_CNT_EN
  ,
  output logic [15:0]            err_total
`endif
);

  localparam int               IDX_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [PM_W-1:0]  PM_MAX   = {PM_W{1'b1}};

  // TSTART is the single cycle between the last ACS step and the first
  // traceback step in which the start state is chosen from the settled PMs.
  typedef enum logic [2:0] {
    ST_LOAD,
    ST_ACS,
    ST_TSTART,
    ST_TRACE,
    ST_OUT
  } state_e;

  state_e                 state_q;
  logic                   inReady_q;
  logic                   outValid_q;
  logic [IDX_W-1:0]       stepCnt_q;
  logic [PM_W-1:0]        pm_q [4];
  logic [PM_W-1:0]        pm_d [4];
  logic [3:0]             surv_d;
  logic [1:0]             curState_q;
  logic [FRAME_LEN-1:0]   decoded_q;
  logic [2*FRAME_LEN-1:0] codeword_q;
  logic [PM_W-1:0]        pmOut_q;

  // Frame storage: received symbols and one survivor bit per state per step.
  logic [1:0]             symMem_q  [FRAME_LEN];
  logic [3:0]             survMem_q [FRAME_LEN];

  logic                   accept;
  logic [1:0]             startState;
  logic [1:0]             minState;
  logic [PM_W-1:0]        minPm;
  logic                   survBit;
  logic [1:0]             traceSym;

`ifdef VITERBI_ERR_CNT_EN
  logic [15:0]            errTotal_q;
  logic [16:0]            errSum;
`endif

  // Branch output for the shift register {u,a,b}.
  function automatic logic [1:0] branchOut(input logic u, input logic a, input logic b);
    logic [2:0] r;
    r = {u, a, b};
    return {^(r & G1), ^(r & G2)};
  endfunction

  // Hamming distance between two 2-bit symbols (0..2).
  function automatic logic [1:0] hamming(input logic [1:0] x, input logic [1:0] y);
    logic [1:0] d;
    d = x ^ y;
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

  // Saturating metric add. An unreachable (PM_MAX) predecessor stays
  // unreachable so it can never beat a genuine path after wrap-around.
  function automatic logic [PM_W-1:0] addSat(input logic [PM_W-1:0] pm, input logic [1:0] bm);
    logic [PM_W:0] s;
    s = {1'b0, pm} + {{(PM_W-1){1'b0}}, bm};
    if (pm == PM_MAX || s[PM_W]) begin
      return PM_MAX;
    end
    return s[PM_W-1:0];
  endfunction

  assign accept = in_valid & inReady_q;

  // Add-compare-select for the current trellis step. State {u,a} has the
  // predecessors {a,0} and {a,1}; on equal candidates the b=0 predecessor
  // wins, which the survivor bit records as 0.
  always_comb begin : acsComb
    logic [PM_W-1:0] cand0;
    logic [PM_W-1:0] cand1;
    logic [1:0]      sym;
    cand0  = '0;
    cand1  = '0;
    sym    = symMem_q[stepCnt_q];
    surv_d = '0;
    for (int ns = 0; ns < 4; ns++) begin
      cand0 = addSat(pm_q[{ns[0], 1'b0}], hamming(branchOut(ns[1], ns[0], 1'b0), sym));
      cand1 = addSat(pm_q[{ns[0], 1'b1}], hamming(branchOut(ns[1], ns[0], 1'b1), sym));
      if (cand0 <= cand1) begin
        pm_d[ns[1:0]]   = cand0;
        surv_d[ns[1:0]] = 1'b0;
      end else begin
        pm_d[ns[1:0]]   = cand1;
        surv_d[ns[1:0]] = 1'b1;
      end
    end
  end

  // Traceback start: state 00 for terminated frames, otherwise the
  // lowest-index state holding the minimum metric (strict < keeps the
  // lower index on ties).
  always_comb begin : startSel
    minState = 2'd0;
    minPm    = pm_q[0];
    for (int s = 1; s < 4; s++) begin
      if (pm_q[s] < minPm) begin
        minPm    = pm_q[s];
        minState = s[1:0];
      end
    end
    startState = (TERMINATED != 0) ? 2'd0 : minState;
  end

  // One traceback step: the survivor bit is the b of the predecessor
  // {s0,b}; the branch taken into the current state re-creates the symbol.
  assign survBit  = survMem_q[stepCnt_q][curState_q];
  assign traceSym = branchOut(curState_q[1], curState_q[0], survBit);

`ifdef VITERBI_ERR_CNT_EN
  assign errSum = {1'b0, errTotal_q} + 17'(pmOut_q);
`endif

  // Frame memories carry pure data and need no reset; stale contents are
  // always overwritten before they are read in the next frame.
  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD && accept) begin
      symMem_q[stepCnt_q] <= in_sym;
    end
    if (state_q == ST_ACS) begin
      survMem_q[stepCnt_q] <= surv_d;
    end
  end

  // Control FSM with registered handshakes and result registers. The step
  // counter counts up while loading and during ACS, then down during
  // traceback so it directly addresses the step being resolved.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_LOAD;
      inReady_q  <= 1'b0;
      outValid_q <= 1'b0;
      stepCnt_q  <= '0;
      pm_q[0]    <= '0;
      pm_q[1]    <= PM_MAX;
      pm_q[2]    <= PM_MAX;
      pm_q[3]    <= PM_MAX;
      curState_q <= 2'd0;
      decoded_q  <= '0;
      codeword_q <= '0;
      pmOut_q    <= '0;
`ifdef VITERBI_ERR_CNT_EN
      errTotal_q <= '0;
`endif
    end else begin
      case (state_q)
        ST_LOAD: begin
          inReady_q <= 1'b1;
          if (accept) begin
            if (stepCnt_q == LAST_IDX) begin
              stepCnt_q <= '0;
              inReady_q <= 1'b0;
              state_q   <= ST_ACS;
            end else begin
              stepCnt_q <= stepCnt_q + 1'b1;
            end
          end
        end
        ST_ACS: begin
          for (int s = 0; s < 4; s++) begin
            pm_q[s] <= pm_d[s];
          end
          if (stepCnt_q == LAST_IDX) begin
            state_q <= ST_TSTART;
          end else begin
            stepCnt_q <= stepCnt_q + 1'b1;
          end
        end
        ST_TSTART: begin
          curState_q <= startState;
          pmOut_q    <= pm_q[startState];
          state_q    <= ST_TRACE;
        end
        ST_TRACE: begin
          decoded_q[stepCnt_q]                 <= curState_q[1];
          codeword_q[{stepCnt_q, 1'b0} +: 2]   <= traceSym;
          curState_q                           <= {curState_q[0], survBit};
          if (stepCnt_q == '0) begin
            outValid_q <= 1'b1;
            state_q    <= ST_OUT;
          end else begin
            stepCnt_q <= stepCnt_q - 1'b1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            stepCnt_q  <= '0;
            pm_q[0]    <= '0;
            pm_q[1]    <= PM_MAX;
            pm_q[2]    <= PM_MAX;
            pm_q[3]    <= PM_MAX;
            state_q    <= ST_LOAD;
`ifdef VITERBI_ERR_CNT_EN
            errTotal_q <= errSum[16] ? 16'hFFFF : errSum[15:0];
`endif
          end
        end
        default: begin
          state_q <= ST_LOAD;
        end
      endcase
    end
  end

  assign in_ready           = inReady_q;
  assign out_valid          = outValid_q;
  assign decoded_bits       = decoded_q;
  assign corrected_codeword = codeword_q;
  assign path_metric_out    = pmOut_q;
`ifdef VITERBI_ERR_CNT_EN
  assign err_total          = errTotal_q;
`endif

endmodule

// File: tb/tb_viterbi_stream_decoder.sv
// ---------------------------------------------------------------------------
// tb_viterbi_stream_decoder
//
// Scoreboard bench for viterbi_stream_decoder. The stimulus process pushes
// the expected frame result into a queue when it sends a frame; an
// independent monitor pops and compares whenever the decoder hands a result
// over. Expected results come from a register-exchange Viterbi model working
// on plain integers, or from known constants for the directed frames.
// ---------------------------------------------------------------------------
module tb_viterbi_stream_decoder;

  localparam int         N      = 8;
  localparam int         PM_W   = 8;
  localparam logic [2:0] G1     = 3'b111;
  localparam logic [2:0] G2     = 3'b101;
  localparam int         TERM   = 1;
  localparam int         PERIOD = 10;
  localparam int         PM_MAX = (1 << PM_W) - 1;

  typedef struct {
    logic [N-1:0]   dec;
    logic [2*N-1:0] cw;
    logic [PM_W-1:0] pm;
  } exp_t;

  logic            clk;
  logic            rstN;
  logic [1:0]      inSym;
  logic            inValid;
  logic            in_ready;
  logic            out_valid;
  logic            outReady;
  logic [N-1:0]    decoded_bits;
  logic [2*N-1:0]  corrected_codeword;
  logic [PM_W-1:0] path_metric_out;
`ifdef VITERBI_ERR_CNT_EN
  logic [15:0]     err_total;
  int              errExp;
`endif

  exp_t  expQ[$];
  int    vectors;
  int    miscompares;
  int    pushed;
  int    handshakes;
  int    readyMode;
  int    stallCnt;
  bit    prevOv;
  bit    readyCheckPending;
  time   acceptTime;
  logic [2*N-1:0] cleanSyms;
  logic [2*N-1:0] errSyms;

  viterbi_stream_decoder #(
    .FRAME_LEN(N), .G1(G1), .G2(G2), .PM_W(PM_W), .TERMINATED(TERM)
  ) dut (
    .clk                (clk),
    .rst                (rstN),
    .in_sym             (inSym),
    .in_valid           (inValid),
    .in_ready           (in_ready),
    .out_valid          (out_valid),
    .out_ready          (outReady),
    .decoded_bits       (decoded_bits),
    .corrected_codeword (corrected_codeword),
    .path_metric_out    (path_metric_out)
`ifdef VITERBI_ERR_CNT_EN
    ,
    .err_total          (err_total)
`endif
  );

  initial clk = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  // Single comparison point: every check steps the counters here.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoder branch: shift register value u*4 + state, parity of each tap set.
  function automatic logic [1:0] encBranch(input int u, input int st);
    int r;
    r = u * 4 + st;
    return {1'($countones(3'(r) & G1) % 2), 1'($countones(3'(r) & G2) % 2)};
  endfunction

  function automatic logic [2*N-1:0] encodeFrame(input logic [N-1:0] bits);
    logic [2*N-1:0] cw;
    int st;
    cw = '0;
    st = 0;
    for (int t = 0; t < N; t++) begin
      cw[2*t +: 2] = encBranch(int'(bits[t]), st);
      st = int'(bits[t]) * 2 + st / 2;
    end
    return cw;
  endfunction

  // Register-exchange Viterbi: each state carries its whole decoded history.
  function automatic exp_t modelFrame(input logic [2*N-1:0] syms);
    int pmv[4];
    int npm[4];
    logic [N-1:0] path[4];
    logic [N-1:0] npath[4];
    int best, bestPrev, cand, prev, st;
    exp_t r;
    pmv = '{0, PM_MAX, PM_MAX, PM_MAX};
    for (int s = 0; s < 4; s++) path[s] = '0;
    for (int t = 0; t < N; t++) begin
      for (int ns = 0; ns < 4; ns++) begin
        best = -1;
        bestPrev = 0;
        for (int b = 0; b < 2; b++) begin
          prev = (ns % 2) * 2 + b;
          if (pmv[prev] == PM_MAX) cand = PM_MAX;
          else begin
            cand = pmv[prev] + $countones(encBranch(ns / 2, prev) ^ syms[2*t +: 2]);
            if (cand > PM_MAX) cand = PM_MAX;
          end
          if (best < 0 || cand < best) begin
            best = cand;
            bestPrev = prev;
          end
        end
        npm[ns] = best;
        npath[ns] = path[bestPrev];
        npath[ns][t] = 1'(ns / 2);
      end
      pmv = npm;
      path = npath;
    end
    st = 0;
    if (TERM == 0) begin
      for (int s = 1; s < 4; s++) if (pmv[s] < pmv[st]) st = s;
    end
    r.dec = path[st];
    r.pm  = PM_W'(pmv[st]);
    r.cw  = encodeFrame(r.dec);
    return r;
  endfunction

  // Drives one frame. gapMode 0: back-to-back, 1: two idle cycles between
  // symbols, 2: random idle cycles. junk drives in_valid with garbage while
  // the decoder is busy, which it must ignore.
  task automatic applyStimulus(input logic [2*N-1:0] syms, input int gapMode, input bit junk);
    bit rdy, got;
    int idle;
    for (int t = 0; t < N; t++) begin
      idle = (t == 0) ? 0 : (gapMode == 1) ? 2 : (gapMode == 2) ? $urandom_range(0, 2) : 0;
      if (idle > 0) begin
        inValid = 1'b0;
        inSym = 2'($urandom);
        repeat (idle) @(posedge clk);
        #1;
      end
      inValid = 1'b1;
      inSym = syms[2*t +: 2];
      got = 1'b0;
      for (int w = 0; w < 1000 && !got; w++) begin
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk);
        if (rdy) got = 1'b1;
      end
      if (!got) begin
        checkOutput("in_ready wait", 64'(in_ready), 64'd1);
        inValid = 1'b0;
        return;
      end
      acceptTime = $time;
      #1;
      inValid = 1'b0;
    end
    if (junk) begin
      inValid = 1'b1;
      repeat (2 * N) begin
        inSym = 2'($urandom);
        @(posedge clk);
        #1;
      end
      inValid = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int w;
    w = 0;
    while (expQ.size() != 0 && w < 2000) begin
      @(posedge clk);
      w++;
    end
    if (expQ.size() != 0) checkOutput("drain timeout", 64'(expQ.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rstN = 1'b0;
    inValid = 1'b0;
    readyCheckPending = 1'b0;
    #2;
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset decoded_bits", 64'(decoded_bits), 64'd0);
    checkOutput("reset codeword", 64'(corrected_codeword), 64'd0);
    checkOutput("reset path_metric", 64'(path_metric_out), 64'd0);
`ifdef VITERBI_ERR_CNT_EN
    checkOutput("reset err_total", 64'(err_total), 64'd0);
    errExp = 0;
`endif
    expQ.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("in_ready after reset", 64'(in_ready), 64'd1);
  endtask

  // Consumer-side ready generator: 0 = always ready, 1 = random,
  // 2 = hold off for five cycles after each out_valid.
  initial begin
    outReady = 1'b0;
    stallCnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid) stallCnt++;
      else stallCnt = 0;
      case (readyMode)
        0:       outReady = 1'b1;
        1:       outReady = ($urandom_range(0, 2) != 0);
        default: outReady = (stallCnt > 5);
      endcase
    end
  end

  // Monitor: samples at the falling edge, between active edges.
  always @(negedge clk) begin
    exp_t e;
    longint lat;
    if (!rstN) begin
      prevOv = 1'b0;
    end else begin
      if (readyCheckPending) begin
        checkOutput("in_ready after handshake", 64'(in_ready), 64'd1);
`ifdef VITERBI_ERR_CNT_EN
        checkOutput("err_total", 64'(err_total), 64'(errExp));
`endif
        readyCheckPending = 1'b0;
      end
      if (out_valid && !prevOv) begin
        lat = longint'(($time - PERIOD/2 - acceptTime) / PERIOD);
        checkOutput("latency", 64'(lat), 64'(2 * N + 1));
        if (expQ.size() == 0) checkOutput("unexpected out_valid", 64'(out_valid), 64'd0);
      end
      if (out_valid && expQ.size() != 0) begin
        if (!outReady) begin
          checkOutput("held decoded_bits", 64'(decoded_bits), 64'(expQ[0].dec));
          checkOutput("held codeword", 64'(corrected_codeword), 64'(expQ[0].cw));
          checkOutput("stall in_ready", 64'(in_ready), 64'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("decoded_bits", 64'(decoded_bits), 64'(e.dec));
          checkOutput("corrected_codeword", 64'(corrected_codeword), 64'(e.cw));
          checkOutput("path_metric_out", 64'(path_metric_out), 64'(e.pm));
`ifdef VITERBI_ERR_CNT_EN
          errExp = (errExp + int'(e.pm) > 65535) ? 65535 : errExp + int'(e.pm);
`endif
          handshakes++;
          readyCheckPending = 1'b1;
        end
      end
      prevOv = out_valid;
    end
  end

  initial begin
    logic [1:0] cleanList[N];
    logic [N-1:0] bits;
    logic [2*N-1:0] syms;
    exp_t e;
    vectors = 0;
    miscompares = 0;
    pushed = 0;
    handshakes = 0;
    readyMode = 0;
    prevOv = 1'b0;
    readyCheckPending = 1'b0;
    acceptTime = 0;
    inSym = 2'b00;
    inValid = 1'b0;
    rstN = 1'b0;
`ifdef VITERBI_ERR_CNT_EN
    errExp = 0;
`endif
    cleanList = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00};
    for (int t = 0; t < N; t++) cleanSyms[2*t +: 2] = cleanList[t];
    errSyms = cleanSyms;
    errSyms[5:4] = 2'b10;

    $display("[TB] reset");
    doReset();

    $display("[TB] clean frame");
    e.dec = 8'b00001101; e.cw = cleanSyms; e.pm = '0;
    expQ.push_back(e); pushed++;
    applyStimulus(cleanSyms, 0, 1'b0);
    waitDrain();

    $display("[TB] single error frame");
    e.pm = PM_W'(1);
    expQ.push_back(e); pushed++;
    applyStimulus(errSyms, 0, 1'b1);
    waitDrain();

    $display("[TB] backpressure");
    readyMode = 2;
    e.pm = '0;
    expQ.push_back(e); pushed++;
    applyStimulus(cleanSyms, 0, 1'b1);
    waitDrain();
    expQ.push_back(e); pushed++;
    applyStimulus(cleanSyms, 0, 1'b0);
    waitDrain();
    readyMode = 0;

    $display("[TB] input gaps");
    expQ.push_back(e); pushed++;
    applyStimulus(cleanSyms, 1, 1'b0);
    waitDrain();

    $display("[TB] reset during ACS");
    applyStimulus(cleanSyms, 0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    doReset();
    expQ.push_back(e); pushed++;
    applyStimulus(cleanSyms, 0, 1'b0);
    waitDrain();
    e.pm = PM_W'(1);
    expQ.push_back(e); pushed++;
    applyStimulus(errSyms, 0, 1'b0);
    waitDrain();
    expQ.push_back(e); pushed++;
    applyStimulus(errSyms, 0, 1'b0);
    waitDrain();

    $display("[TB] random frames");
    readyMode = 1;
    for (int f = 0; f < 40; f++) begin
      bits = N'($urandom);
      bits[N-1] = 1'b0;
      bits[N-2] = 1'b0;
      syms = encodeFrame(bits);
      for (int k = $urandom_range(0, 3); k > 0; k--) syms[$urandom_range(0, 2*N-1)] ^= 1'b1;
      expQ.push_back(modelFrame(syms));
      pushed++;
      applyStimulus(syms, 2, f[0]);
    end
    waitDrain();

    checkOutput("handshake count", 64'(handshakes), 64'(pushed));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #(PERIOD * 90000);
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
